// File: rtl/percept_bus_pkg.sv
// Shared types and constants for the percept broadcast-line scheduler.
// Build option: define PERCEPT_BUS_PARITY_EN to append an even-parity bit to
// every frame. The percept_if nodes must be built with the same setting.
package percept_bus_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

`ifdef PERCEPT_BUS_PARITY_EN
  localparam int unsigned FRAME_BITS = 18;
`else
  localparam int unsigned FRAME_BITS = 17;
`endif

  // Level the broadcast line rests at between frames
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_DATA,
    ST_PAR,
    ST_GAP
  } bus_state_e;

  // Even parity over the whole payload: XOR of all address and data bits
  function automatic logic even_parity(input logic [ADDR_W-1:0] addr,
                                       input logic [DATA_W-1:0] data);
    return ^{addr, data};
  endfunction

endpackage

// File: rtl/percept_bus_sched_arb.sv
// percept_rr_arb: combinational N_REQ-way round-robin picker.
// Ports:
//   valid - request vector
//   ptr   - index of the last granted requester (search starts at ptr+1)
//   grant - one-hot grant, all zero when nothing is valid
//   idx   - binary index of the granted requester (0 when nothing is valid)
module percept_rr_arb
  import percept_bus_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDW   = 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx
);

  logic           found;
  logic [IDW-1:0] cand;

  // Walk the ring starting just after ptr; first valid entry wins
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDW'((32'(ptr) + k) % N_REQ);
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/percept_bus_sched.sv
// percept_bus_sched: sole driver of the percept_if broadcast serial line.
// Grants requesters round-robin and sends each grant as one frame:
// start bit (0), address MSB first, data MSB first, [parity], then an
// idle-high guard gap of GAP cycles.
// Build option: PERCEPT_BUS_PARITY_EN adds an even-parity bit after the data.
// Ports:
//   clk, nRst           - clock, asynchronous active-low reset
//   req_valid[i]        - requester i has a frame pending
//   req_addr/req_data   - byte i in bits [8i+7:8i]
//   req_ack[i]          - one-cycle pulse when requester i's frame is captured
//   grant_id            - index of the requester being sent (held afterwards)
//   busy                - high from start bit through end of guard gap
//   frame_done          - pulse on first idle-high cycle after the last frame bit
//   serial_out          - broadcast line, idle high
module percept_bus_sched
  import percept_bus_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned GAP   = 2,
  parameter int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [ADDR_W*N_REQ-1:0] req_addr,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ack,
  output logic [IDW-1:0]          grant_id,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    serial_out
);

  localparam int unsigned BCW = 3;
  localparam int unsigned GCW = 4;

  bus_state_e        state;
  logic [IDW-1:0]    ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [BCW-1:0]    bit_cnt;
  logic [GCW-1:0]    gap_cnt;

  logic [N_REQ-1:0]  arb_grant;
  logic [IDW-1:0]    arb_idx;

  percept_rr_arb #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Frame sequencer; every output is loaded with the value for the state
  // being entered so the line and status change together with the state.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= ST_IDLE;
      ptr        <= IDW'(N_REQ - 1);
      addr_q     <= '0;
      data_q     <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      serial_out <= LINE_IDLE;
      req_ack    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      grant_id   <= '0;
    end else begin
      req_ack    <= '0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            addr_q     <= req_addr[32'(arb_idx)*ADDR_W +: ADDR_W];
            data_q     <= req_data[32'(arb_idx)*DATA_W +: DATA_W];
            req_ack    <= arb_grant;
            grant_id   <= arb_idx;
            ptr        <= arb_idx;
            busy       <= 1'b1;
            serial_out <= 1'b0;
            state      <= ST_START;
          end else begin
            serial_out <= LINE_IDLE;
          end
        end
        ST_START: begin
          bit_cnt    <= BCW'(ADDR_W - 1);
          serial_out <= addr_q[ADDR_W-1];
          state      <= ST_ADDR;
        end
        ST_ADDR: begin
          if (bit_cnt == '0) begin
            bit_cnt    <= BCW'(DATA_W - 1);
            serial_out <= data_q[DATA_W-1];
            state      <= ST_DATA;
          end else begin
            bit_cnt    <= bit_cnt - BCW'(1);
            serial_out <= addr_q[bit_cnt - BCW'(1)];
          end
        end
        ST_DATA: begin
          if (bit_cnt == '0) begin
`ifdef PERCEPT_BUS_PARITY_EN
            serial_out <= even_parity(addr_q, data_q);
            state      <= ST_PAR;
`else
            serial_out <= LINE_IDLE;
            frame_done <= 1'b1;
            gap_cnt    <= GCW'(GAP - 1);
            state      <= ST_GAP;
`endif
          end else begin
            bit_cnt    <= bit_cnt - BCW'(1);
            serial_out <= data_q[bit_cnt - BCW'(1)];
          end
        end
        ST_PAR: begin
          serial_out <= LINE_IDLE;
          frame_done <= 1'b1;
          gap_cnt    <= GCW'(GAP - 1);
          state      <= ST_GAP;
        end
        ST_GAP: begin
          serial_out <= LINE_IDLE;
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GCW'(1);
          end
        end
        default: begin
          serial_out <= LINE_IDLE;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_percept_bus_sched.sv
// Scoreboard bench for percept_bus_sched: a round-robin/line-occupancy model
// predicts each frame when it is granted; a negedge monitor decodes the line.
module tb_percept_bus_sched;

  localparam int unsigned N_REQ = 2;
  localparam int unsigned GAP   = 2;
  localparam int unsigned IDW   = 1;
`ifdef PERCEPT_BUS_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int DONE_POS = 17 + PAR_BITS;
  localparam int PERIOD   = 18 + int'(GAP) + PAR_BITS;

  logic                 clk;
  logic                 nRst;
  logic [N_REQ-1:0]     req_valid;
  logic [8*N_REQ-1:0]   req_addr;
  logic [8*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]     req_ack;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 frame_done;
  logic                 serial_out;

  percept_bus_sched #(.N_REQ(N_REQ), .GAP(GAP)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .grant_id   (grant_id),
    .busy       (busy),
    .frame_done (frame_done),
    .serial_out (serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] addr;
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t exp_q[$];
  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the line is free again PERIOD cycles after a grant;
  // when free, the first valid requester after the last winner is granted.
  int     model_ptr = N_REQ - 1;
  int     free_at   = 0;
  int     mj;
  frame_t nf;
  always @(posedge clk) begin
    if (!nRst) begin
      model_ptr = N_REQ - 1;
      free_at   = 0;
      exp_q.delete();
    end else if (cyc >= free_at && req_valid != '0) begin
      for (int k = 1; k <= N_REQ; k++) begin
        mj = (model_ptr + k) % N_REQ;
        if (req_valid[mj]) begin
          nf.idx   = mj;
          nf.addr  = req_addr[8*mj +: 8];
          nf.data  = req_data[8*mj +: 8];
          nf.start = cyc + 1;
          exp_q.push_back(nf);
          model_ptr = mj;
          free_at   = cyc + PERIOD;
          break;
        end
      end
    end
    cyc = cyc + 1;
  end

  // Monitor: decodes the line relative to each ack and compares to the queue
  frame_t     cur;
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic       exp_bit;
  always @(negedge clk) begin
    if (!nRst) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (req_ack != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(req_ack), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("ack_onehot", 32'(req_ack), 32'd1 << cur.idx);
          check("grant_id", 32'(grant_id), 32'(cur.idx));
          check("start_cycle", 32'(cyc), 32'(cur.start));
          check("start_bit", 32'(serial_out), 32'd0);
          check("busy_start", 32'(busy), 32'd1);
          m_active = 1'b1;
          m_pos    = 1;
        end
      end else begin
        check("idle_line", 32'(serial_out), 32'd1);
        check("idle_frame_done", 32'(frame_done), 32'd0);
        if (exp_q.size() != 0 && cyc > exp_q[0].start) begin
          check("missing_ack_cycle", 32'(cyc), 32'(exp_q[0].start));
          void'(exp_q.pop_front());
        end
      end
    end else begin
      if (m_pos <= 8)       exp_bit = cur.addr[8 - m_pos];
      else if (m_pos <= 16) exp_bit = cur.data[16 - m_pos];
      else if (m_pos < DONE_POS) exp_bit = ^{cur.addr, cur.data};
      else                  exp_bit = 1'b1;
      if (m_pos < DONE_POS) begin
        check("frame_bit", 32'(serial_out), 32'(exp_bit));
        check("busy_frame", 32'(busy), 32'd1);
        check("done_early", 32'(frame_done), 32'd0);
        check("ack_in_frame", 32'(req_ack), 32'd0);
      end else if (m_pos < DONE_POS + int'(GAP)) begin
        check("gap_line", 32'(serial_out), 32'd1);
        check("busy_gap", 32'(busy), 32'd1);
        check("frame_done", 32'(frame_done), (m_pos == DONE_POS) ? 32'd1 : 32'd0);
      end else begin
        check("busy_fall", 32'(busy), 32'd0);
        check("post_gap_line", 32'(serial_out), 32'd1);
        check("post_gap_done", 32'(frame_done), 32'd0);
        m_active = 1'b0;
      end
      m_pos++;
    end
  end

  task automatic new_frame(input int i);
    req_valid[i]       = 1'b1;
    req_addr[8*i +: 8] = 8'($urandom);
    req_data[8*i +: 8] = 8'($urandom);
  endtask

  // sat=1: every requester re-requests immediately after its ack
  task automatic run_traffic(input int cycles, input bit sat);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ack[i]) begin
          if (sat || $urandom_range(1, 0) == 1) new_frame(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if (sat || $urandom_range(2, 0) == 0) new_frame(i);
        end else if (!sat && $urandom_range(24, 0) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    @(posedge clk); #3;
    req_valid = '0;
  endtask

  task automatic wait_ack(input int i, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!req_ack[i] && n < 4 * PERIOD);
    check(name, 32'(req_ack[i]), 32'd1);
  endtask

  initial begin
    nRst      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_serial", 32'(serial_out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    #1 nRst = 1'b1;

    // Quiet line after reset
    repeat (50) @(posedge clk);

    // Single directed frame from requester 0
    #1;
    req_valid[0]  = 1'b1;
    req_addr[7:0] = 8'h02;
    req_data[7:0] = 8'hA5;
    wait_ack(0, "ack_req0_directed");
    req_valid[0] = 1'b0;
    repeat (PERIOD + 2) @(posedge clk);

    // Requester 1 withdraws while requester 0's frame is in flight
    #1;
    req_valid[0]  = 1'b1;
    req_addr[7:0] = 8'h3C;
    req_data[7:0] = 8'h5A;
    wait_ack(0, "ack_req0_before_drop");
    req_valid[0]   = 1'b0;
    req_valid[1]   = 1'b1;
    req_addr[15:8] = 8'h77;
    req_data[15:8] = 8'h11;
    repeat (5) @(posedge clk);
    #1 req_valid[1] = 1'b0;
    repeat (2 * PERIOD) @(posedge clk);

    // Saturated load, then random traffic with occasional withdrawals
    run_traffic(10 * PERIOD, 1'b1);
    repeat (2 * PERIOD) @(posedge clk);
    run_traffic(3000, 1'b0);
    repeat (2 * PERIOD) @(posedge clk);

    // Reset in the middle of an all-zero address
    #1;
    req_valid[0]  = 1'b1;
    req_addr[7:0] = 8'h00;
    req_data[7:0] = 8'hFF;
    wait_ack(0, "ack_before_reset");
    req_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    #3 nRst = 1'b0;
    #1;
    check("reset_mid_serial", 32'(serial_out), 32'd1);
    check("reset_mid_busy", 32'(busy), 32'd0);
    check("reset_mid_ack", 32'(req_ack), 32'd0);
    req_valid = 2'b11;
    req_addr  = 16'hC381;
    req_data  = 16'h4E96;
    repeat (3) @(posedge clk);
    #3 nRst = 1'b1;
    wait_ack(0, "first_after_reset_req0");
    check("first_after_reset_onehot", 32'(req_ack), 32'd1);
    req_valid[0] = 1'b0;
    wait_ack(1, "second_after_reset_req1");
    req_valid[1] = 1'b0;
    repeat (2 * PERIOD) @(posedge clk);

    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("monitor_idle", 32'(m_active), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/percept_bus_sched.md
# percept_bus_sched

Scheduler that shares the single broadcast serial line feeding the `percept_if` nodes between several requesters, e.g. the UART host path and an on-chip training sequencer. Each requester offers an {address, data} byte pair. The block grants requesters round-robin and serialises each grant as one frame: start bit, address byte, then data byte. It enforces an idle guard gap between frames. It replaces the ad-hoc shift state machine in the top level as the sole driver of `serial`.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters. Legal range 1..8.
- `GAP`, default 2: minimum idle-high cycles between frames. Legal range 1..15.
- `IDW`, default max(1, clog2(N_REQ)): grant index width. Derived; never overridden.

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `nRst` input 1: reset, asynchronous, active-low.
- `req_valid` input N_REQ: requester i has a frame pending.
- `req_addr` input 8·N_REQ: address for requester i, in bits [8i+7:8i].
- `req_data` input 8·N_REQ: data for requester i, in bits [8i+7:8i].
- `req_ack` output N_REQ: one-cycle pulse when the frame of requester i is captured.
- `grant_id` output IDW: index of the requester currently being sent. Holds its value after the frame ends.
- `busy` output 1: high from the start bit through the end of the guard gap.
- `frame_done` output 1: one-cycle pulse on the first idle-high cycle after the last frame bit.
- `serial_out` output 1: broadcast line to the `percept_if` nodes. Idle level is 1.

## Operation
- States: IDLE → START → ADDR → DATA → [PAR] → GAP → IDLE.
- All outputs are registered.
- Reset values: `serial_out`=1, `req_ack`=0, `busy`=0, `frame_done`=0, `grant_id`=0, state=IDLE. The round-robin pointer resets to N_REQ-1, so requester 0 has first priority.
- IDLE: if any `req_valid` bit is set, the arbiter picks the first valid index at or after pointer+1, modulo N_REQ. The block then:
  - latches that requester's addr and data,
  - pulses `req_ack[i]`,
  - sets `grant_id`=i,
  - advances the pointer to i,
  - moves to START.
- If nothing is valid in IDLE, the block stays in IDLE with `serial_out`=1.
- START: `serial_out`=0 for one cycle.
- ADDR: address bits 7..0, MSB first, one bit per cycle. An 8-cycle bit counter runs from 7 down to 0.
- DATA: data bits 7..0, MSB first, same counter.
- GAP: `serial_out`=1 for GAP cycles. `frame_done` pulses on the first GAP cycle.
- Handshake: a requester holds `req_valid`, addr and data stable until it sees its `req_ack`. The block samples them only in the IDLE cycle that grants. After `req_ack` the requester may change them immediately.
- Simultaneous requests: the non-granted requesters wait. Round-robin guarantees each waits at most N_REQ-1 frames.
- `req_valid` dropping without an ack is legal. The request is simply not served.
- Reset mid-frame: the frame is abandoned. `serial_out` goes to 1 asynchronously. The interrupted requester received its ack earlier and must re-present the frame.
- With N_REQ=1 the arbiter degenerates to a direct grant of requester 0.

## Timing
- Let T be the IDLE cycle in which `req_valid[i]` is sampled.
- T+1: `req_ack[i]`=1, `busy`=1, `serial_out`=0 (start bit).
- T+2..T+9: address bits 7..0.
- T+10..T+17: data bits 7..0.
- T+18: `serial_out`=1 and `frame_done`=1. The line stays high for GAP cycles.
- Frame length is 17 cycles. Start-to-start period is 18+GAP cycles under back-to-back load.
- `busy` falls in the cycle the state returns to IDLE. That cycle is also the first cycle in which a new grant can be sampled.

## Configuration
- Macro `PERCEPT_BUS_PARITY_EN`.
- Defined: a PAR state follows DATA. It sends one even-parity bit, the XOR of all 16 addr and data bits, at T+18. `frame_done` moves to T+19, and the period becomes 19+GAP.
- Undefined: no PAR state. Timing is exactly as above.
- The `percept_if` nodes must be built with the same setting.

## Structure
- Package `percept_bus_pkg` holds:
  - the state enum,
  - `ADDR_W`=8 and `DATA_W`=8,
  - `FRAME_BITS` (17, or 18 when `PERCEPT_BUS_PARITY_EN` is defined),
  - the idle line level constant.
- Sub-module `percept_rr_arb`: a combinational N_REQ-way round-robin picker. Inputs are valid and pointer; outputs are a one-hot grant and an index. The pointer register lives in the parent.

## Test plan
1. After reset, no requests → `serial_out`=1, `busy`=0, no ack for 50 cycles.
2. Requester 0 sends addr 0x02, data 0xA5 → ack at T+1; line carries 0, 00000010, 10100101 over T+1..T+17; `frame_done` at T+18.
3. Both requesters held valid continuously, GAP=2 → acks alternate 0,1,0,1; start bits exactly 20 cycles apart.
4. `nRst` asserted at T+8 mid-address → `serial_out`=1 immediately. After release, requester 0 wins first again.
5. With `PERCEPT_BUS_PARITY_EN`, addr 0x01, data 0x03 → parity bit 1 at T+18; `frame_done` at T+19.
6. Requester 1 drops `req_valid` while requester 0's frame is in flight → no ack for requester 1 and no spurious frame.
